mousetrap_pipe: RTL and testbench

Parametrised, single-clock successor of the transition-signalling latch stage: a chain of DEPTH stages, each carrying a WIDTH-bit data word bundled with a two-phase (toggle) request/acknowledge pair. It sits between two two-phase handshake domains of the SoC datapath as an elastic buffer. It adds bundled data, configurable depth, an occupancy count and per-stage enable visibility; the single-bit stage lacked all four.

---
 rtl/mousetrap_pkg.sv | 12 +
 rtl/mousetrap_stage.sv | 59 +++++
 rtl/mousetrap_pipe.sv | 82 ++++++++
 tb/tb_mousetrap_pipe.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mousetrap_pkg.sv
// Shared constants and helpers for the two-phase bundled-data pipeline.
// Optional scan chain on phase bits: MOUSETRAP_PIPE_SCAN_EN.
package mousetrap_pkg;

  localparam logic MT_PHASE_RST    = 1'b0;
  localparam logic MT_DATA_RST_BIT = 1'b0;

  function automatic int mt_occ_w(input int depth);
    return (depth < 1) ? 1 : $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/mousetrap_stage.sv
// One toggle-handshake stage: phase bit, data register, enable L.
// Scan shift of the phase bit when MOUSETRAP_PIPE_SCAN_EN is defined.
module mousetrap_stage
  import mousetrap_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             phi1,
  input  logic             reset_n,
  input  logic             in_phase,
  input  logic [WIDTH-1:0] in_data,
  input  logic             ack,
`ifdef MOUSETRAP_PIPE_SCAN_EN
  input  logic             test_se,
  input  logic             test_si,
`endif
  output logic             phase,
  output logic [WIDTH-1:0] data,
  output logic             l
);

  typedef struct packed {
    logic             phase;
    logic [WIDTH-1:0] data;
  } stage_t;

  stage_t st_q, st_d;

  assign l     = ~(st_q.phase ^ ack);
  assign phase = st_q.phase;
  assign data  = st_q.data;

  always_comb begin
    st_d = st_q;
`ifdef MOUSETRAP_PIPE_SCAN_EN
    if (test_se) begin
      st_d.phase = test_si;
    end else if (l && (in_phase != st_q.phase)) begin
      st_d.phase = in_phase;
      st_d.data  = in_data;
    end
`else
    if (l && (in_phase != st_q.phase)) begin
      st_d.phase = in_phase;
      st_d.data  = in_data;
    end
`endif
  end

  always_ff @(posedge phi1 or negedge reset_n) begin
    if (!reset_n) begin
      st_q.phase <= MT_PHASE_RST;
      st_q.data  <= {WIDTH{MT_DATA_RST_BIT}};
    end else begin
      st_q <= st_d;
    end
  end

endmodule

// File: rtl/mousetrap_pipe.sv
// Elastic two-phase pipeline of DEPTH mousetrap_stage instances + occupancy.
// Scan ports test_se/test_si/test_so exist only with MOUSETRAP_PIPE_SCAN_EN.
module mousetrap_pipe
  import mousetrap_pkg::*;
#(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 4,
  localparam int OCC_W = mt_occ_w(DEPTH)
) (
  input  logic             phi1,
  input  logic             reset_n,
  input  logic             ri,
  input  logic [WIDTH-1:0] din,
  output logic             ai,
  output logic             ro,
  output logic [WIDTH-1:0] dout,
  input  logic             ao,
`ifdef MOUSETRAP_PIPE_SCAN_EN
  input  logic             test_se,
  input  logic             test_si,
  output logic             test_so,
`endif
  output logic [DEPTH-1:0] L,
  output logic [OCC_W-1:0] occ
);

  logic [DEPTH-1:0] p;
  logic [DEPTH-1:0] ack;
  logic [DEPTH-1:0] in_p;
  logic [WIDTH-1:0] d    [DEPTH];
  logic [WIDTH-1:0] in_d [DEPTH];

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    if (k == 0) begin : g_head
      assign in_p[k] = ri;
      assign in_d[k] = din;
    end else begin : g_body
      assign in_p[k] = p[k-1];
      assign in_d[k] = d[k-1];
    end

    if (k == DEPTH - 1) begin : g_tail
      assign ack[k] = ao;
    end else begin : g_mid
      assign ack[k] = p[k+1];
    end

    mousetrap_stage #(
      .WIDTH(WIDTH)
    ) u_stage (
      .phi1    (phi1),
      .reset_n (reset_n),
      .in_phase(in_p[k]),
      .in_data (in_d[k]),
      .ack     (ack[k]),
`ifdef MOUSETRAP_PIPE_SCAN_EN
      .test_se (test_se),
      .test_si ((k == 0) ? test_si : in_p[k]),
`endif
      .phase   (p[k]),
      .data    (d[k]),
      .l       (L[k])
    );
  end

  assign ai   = p[0];
  assign ro   = p[DEPTH-1];
  assign dout = d[DEPTH-1];

`ifdef MOUSETRAP_PIPE_SCAN_EN
  assign test_so = p[DEPTH-1];
`endif

  // A stage is full exactly when its enable is low.
  always_comb begin
    occ = '0;
    for (int k = 0; k < DEPTH; k++) begin
      occ = occ + OCC_W'(~L[k]);
    end
  end

endmodule

// File: tb/tb_mousetrap_pipe.sv
// Directed bench for mousetrap_pipe (WIDTH=8, DEPTH=4).
// Scan sequence compiled in with MOUSETRAP_PIPE_SCAN_EN.
module tb_mousetrap_pipe;

  logic       phi1 = 1'b0;
  logic       reset_n;
  logic       ri;
  logic [7:0] din;
  logic       ai;
  logic       ro;
  logic [7:0] dout;
  logic       ao;
  logic [3:0] L;
  logic [2:0] occ;
`ifdef MOUSETRAP_PIPE_SCAN_EN
  logic       test_se;
  logic       test_si;
  logic       test_so;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 phi1 = ~phi1;

  mousetrap_pipe #(
    .WIDTH(8),
    .DEPTH(4)
  ) dut (
    .phi1   (phi1),
    .reset_n(reset_n),
    .ri     (ri),
    .din    (din),
    .ai     (ai),
    .ro     (ro),
    .dout   (dout),
    .ao     (ao),
`ifdef MOUSETRAP_PIPE_SCAN_EN
    .test_se(test_se),
    .test_si(test_si),
    .test_so(test_so),
`endif
    .L      (L),
    .occ    (occ)
  );

  typedef struct {
    logic       ri;
    logic       ao;
    logic [7:0] din;
    logic       e_ai;
    logic       e_ro;
    logic [7:0] e_dout;
    logic [3:0] e_l;
    logic [2:0] e_occ;
  } vec_t;

  vec_t tbl [10];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge phi1);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int sent;
    int got;
    int cyc;
    int last;
    int bad_iv;
    logic [7:0] exp_q [$];
    logic [7:0] e;

    // single token A5, then token 3C back through the empty pipe
    tbl[0] = '{1'b1, 1'b0, 8'hA5, 1'b1, 1'b0, 8'h00, 4'b1110, 3'd1};
    tbl[1] = '{1'b1, 1'b0, 8'hA5, 1'b1, 1'b0, 8'h00, 4'b1101, 3'd1};
    tbl[2] = '{1'b1, 1'b0, 8'hA5, 1'b1, 1'b0, 8'h00, 4'b1011, 3'd1};
    tbl[3] = '{1'b1, 1'b0, 8'hA5, 1'b1, 1'b1, 8'hA5, 4'b0111, 3'd1};
    tbl[4] = '{1'b1, 1'b1, 8'hA5, 1'b1, 1'b1, 8'hA5, 4'b1111, 3'd0};
    tbl[5] = '{1'b0, 1'b1, 8'h3C, 1'b0, 1'b1, 8'hA5, 4'b1110, 3'd1};
    tbl[6] = '{1'b0, 1'b1, 8'h3C, 1'b0, 1'b1, 8'hA5, 4'b1101, 3'd1};
    tbl[7] = '{1'b0, 1'b1, 8'h3C, 1'b0, 1'b1, 8'hA5, 4'b1011, 3'd1};
    tbl[8] = '{1'b0, 1'b1, 8'h3C, 1'b0, 1'b0, 8'h3C, 4'b0111, 3'd1};
    tbl[9] = '{1'b0, 1'b0, 8'h3C, 1'b0, 1'b0, 8'h3C, 4'b1111, 3'd0};

`ifdef MOUSETRAP_PIPE_SCAN_EN
    test_se = 1'b0;
    test_si = 1'b0;
`endif
    reset_n = 1'b0;
    ri      = 1'b1;
    ao      = 1'b1;
    din     = 8'h00;
    #1;
    chk("rst_ai", ai, 1'b0);
    chk("rst_ro", ro, 1'b0);
    chk("rst_dout", dout, 8'h00);
    ao = 1'b0;
    #1;
    chk("rst_occ", occ, 3'd0);
    chk("rst_l", L, 4'b1111);
    ri = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      ri  = tbl[i].ri;
      ao  = tbl[i].ao;
      din = tbl[i].din;
      tick();
      chk($sformatf("vec%0d_ai", i), ai, tbl[i].e_ai);
      chk($sformatf("vec%0d_ro", i), ro, tbl[i].e_ro);
      chk($sformatf("vec%0d_dout", i), dout, tbl[i].e_dout);
      chk($sformatf("vec%0d_l", i), L, tbl[i].e_l);
      chk($sformatf("vec%0d_occ", i), occ, tbl[i].e_occ);
    end

    // fill and stall: five tokens offered, consumer idle
    sent = 0;
    for (int c = 0; c < 20; c++) begin
      if (ri == ai && sent < 5) begin
        din = 8'(sent + 1);
        ri  = ~ri;
        sent++;
      end
      tick();
    end
    chk("fill_sent", sent, 5);
    chk("fill_occ", occ, 3'd4);
    chk("fill_l", L, 4'b0000);
    chk("fill_pending", ri ^ ai, 1'b1);
    chk("fill_din_held", din, 8'h05);

    got = 0;
    for (int c = 0; c < 100 && got < 5; c++) begin
      if (ro != ao) begin
        chk($sformatf("drain_tok%0d", got), dout, 8'(got + 1));
        got++;
        ao = ~ao;
      end
      tick();
    end
    chk("drain_count", got, 5);
    chk("drain_occ", occ, 3'd0);

    // streaming with immediate producer and consumer
    sent   = 0;
    got    = 0;
    last   = 0;
    bad_iv = 0;
    for (cyc = 0; cyc < 2000 && got < 100; cyc++) begin
      if (ro != ao) begin
        chk("stream_avail", exp_q.size() > 0, 1'b1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk($sformatf("stream_tok%0d", got), dout, e);
        end
        if (got >= 10 && cyc - last != 2) bad_iv++;
        last = cyc;
        got++;
        ao = ~ao;
      end
      if (ri == ai && sent < 100) begin
        din = 8'($urandom);
        ri  = ~ri;
        exp_q.push_back(din);
        sent++;
      end
      tick();
    end
    chk("stream_count", got, 100);
    chk("stream_interval", bad_iv, 0);
    chk("stream_leftover", exp_q.size(), 0);

    // three tokens inside, then asynchronous reset between edges
    sent = 0;
    for (int c = 0; c < 12; c++) begin
      if (ri == ai && sent < 3) begin
        din = 8'(8'h10 + sent);
        ri  = ~ri;
        sent++;
      end
      tick();
    end
    chk("mid_occ_before", occ, 3'd3);
    #2;
    reset_n = 1'b0;
    ri      = 1'b0;
    ao      = 1'b0;
    #1;
    chk("mid_ro", ro, 1'b0);
    chk("mid_ai", ai, 1'b0);
    chk("mid_occ", occ, 3'd0);
    chk("mid_dout", dout, 8'h00);
    tick();
    reset_n = 1'b1;
    ri  = 1'b1;
    din = 8'h5A;
    got = 0;
    for (int c = 0; c < 20 && ro == ao; c++) begin
      tick();
      got++;
    end
    chk("post_rst_latency", got, 4);
    chk("post_rst_ro", ro, 1'b1);
    chk("post_rst_dout", dout, 8'h5A);
    chk("post_rst_ai", ai, 1'b1);

`ifdef MOUSETRAP_PIPE_SCAN_EN
    begin
      logic pat [4];
      pat     = '{1'b1, 1'b0, 1'b1, 1'b1};
      test_se = 1'b1;
      for (int i = 0; i < 4; i++) begin
        chk($sformatf("scan_old%0d", i), test_so, 1'b1);
        test_si = pat[i];
        tick();
        chk($sformatf("scan_dout%0d", i), dout, 8'h5A);
      end
      chk("scan_p0", ai, pat[3]);
      chk("scan_p3", ro, pat[0]);
      for (int i = 0; i < 4; i++) begin
        chk($sformatf("scan_out%0d", i), test_so, pat[i]);
        test_si = 1'b0;
        tick();
      end
      chk("scan_dout_end", dout, 8'h5A);
      test_se = 1'b0;
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
